multi_channel_timer: RTL and testbench

- Parametrised successor to the single-rate microsecond timer.
- One shared prescaler turns the system clock into a base tick, by default 1 us at 50 MHz.
- CH independent channel counters run off that tick. Each channel has its own run, clear, limit and wrap/stop mode, and raises a one-cycle done pulse when it reaches its limit.
- Used by note-timing and game-timer logic that needs several concurrent durations from one timebase.

---
 rtl/multi_channel_timer_pkg.sv | 9 +
 rtl/multi_channel_timer_if.sv | 22 ++
 rtl/multi_channel_timer_channel.sv | 35 +++
 rtl/multi_channel_timer.sv | 45 ++++
 tb/tb_multi_channel_timer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/multi_channel_timer_pkg.sv
// multi_channel_timer_pkg: shared mode encodings, default divider and prescaler width helper
package multi_channel_timer_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_STOP = 1'b1;
  localparam int DEFAULT_DIV = 50;
  function automatic int div_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/multi_channel_timer_if.sv
// multi_channel_timer_if: control and status bundle between a timer user and the timer
interface multi_channel_timer_if #(
  parameter int CH = 4,
  parameter int W  = 29
);
  logic            tick_en;
  logic [CH-1:0]   ch_run;
  logic [CH-1:0]   ch_clear;
  logic [CH-1:0]   ch_mode;
  logic [CH*W-1:0] ch_limit;
  logic            tick;
  logic [CH*W-1:0] ch_count;
  logic [CH-1:0]   ch_done;
  modport master (
    output tick_en, ch_run, ch_clear, ch_mode, ch_limit,
    input  tick, ch_count, ch_done
  );
  modport slave (
    input  tick_en, ch_run, ch_clear, ch_mode, ch_limit,
    output tick, ch_count, ch_done
  );
endinterface

// File: rtl/multi_channel_timer_channel.sv
// timer_channel: one channel counter with clear/run/limit/mode priority and done pulse
module timer_channel
  import multi_channel_timer_pkg::*;
#(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         adv,
  input  logic         clear,
  input  logic         mode,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         done
);
  logic [W-1:0] inc, n_count;
  logic         at_lim, idle, n_done;
  assign inc    = count + W'(1);
  assign at_lim = count >= limit;
  assign idle   = limit == '0;
  // next state in priority order: clear, no advance, idle limit, at/over limit, increment
  always_comb begin
    n_count = clear ? '0 : !adv ? count : idle ? '0 : at_lim ? (mode == MODE_WRAP ? '0 : count) : inc;
    n_done  = !clear && adv && !idle && !at_lim && inc == limit;
  end
  // count and done registers
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      count <= n_count;
      done  <= n_done;
    end
endmodule

// File: rtl/multi_channel_timer.sv
// multi_channel_timer: shared prescaler driving CH independent limit counters
module multi_channel_timer
  import multi_channel_timer_pkg::*;
#(
  parameter int CH  = 4,
  parameter int W   = 29,
  parameter int DIV = DEFAULT_DIV
) (
  input logic                   clk,
  input logic                   resetn,
  multi_channel_timer_if.slave  bus
);
  localparam int DIV_W = div_width(DIV);
  logic [DIV_W-1:0] presc;
  logic             last;
  logic [W-1:0]     cnt [CH];
  logic [CH-1:0]    done_v;
  assign last = presc == DIV_W'(DIV - 1);
  // prescaler and registered base tick; disabled cycles hold phase and emit no tick
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      presc    <= '0;
      bus.tick <= 1'b0;
    end else if (bus.tick_en) begin
      presc    <= last ? '0 : presc + DIV_W'(1);
      bus.tick <= last;
    end else
      bus.tick <= 1'b0;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    timer_channel #(.W(W)) u_ch (
      .clk    (clk),
      .resetn (resetn),
      .adv    (bus.tick & bus.ch_run[i]),
      .clear  (bus.ch_clear[i]),
      .mode   (bus.ch_mode[i]),
      .limit  (bus.ch_limit[i*W +: W]),
      .count  (cnt[i]),
      .done   (done_v[i])
    );
  end
  // pack per-channel counts onto the bus
  always_comb
    for (int k = 0; k < CH; k++) bus.ch_count[k*W +: W] = cnt[k];
  assign bus.ch_done = done_v;
endmodule

// File: tb/tb_multi_channel_timer.sv
// tb_multi_channel_timer: directed vectors and corner sequences for multi_channel_timer
module tb_multi_channel_timer;
  localparam logic [28:0] LIM = 29'd536870911;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;
  int d1_pulses = 0;
  logic [1:0] seen = 2'b00;
  always #5 clk = ~clk;
  multi_channel_timer_if #(.CH(2), .W(8)) bus ();
  multi_channel_timer_if #(.CH(1), .W(29)) bus2 ();
  multi_channel_timer #(.CH(2), .W(8), .DIV(4)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  multi_channel_timer #(.CH(1), .W(29), .DIV(1)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2));
  typedef struct {
    logic       en;
    logic [1:0] run, clr, mode;
    logic [7:0] l0, l1;
    int         n;
    logic       tk;
    logic [7:0] c0, c1;
    logic [1:0] dn;
  } vec_t;
  vec_t tbl[14];
  function automatic vec_t mk(input logic en, input logic [1:0] run, clr, mode, input logic [7:0] l0, l1,
                              input int n, input logic tk, input logic [7:0] c0, c1, input logic [1:0] dn);
    mk = '{en, run, clr, mode, l0, l1, n, tk, c0, c1, dn};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    seen |= bus.ch_done;
    d1_pulses += int'(bus.ch_done[1]);
  endtask
  task automatic next_tick;
    bit got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      step();
      got = bus.tick;
    end
    chk("tick_timeout", {31'd0, got}, 32'd1);
  endtask
  task automatic adv;
    next_tick();
    step();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.tick_en = 1'b0; bus.ch_run = '0; bus.ch_clear = '0; bus.ch_mode = '0; bus.ch_limit = '0;
    bus2.tick_en = 1'b1; bus2.ch_run = 1'b0; bus2.ch_clear = 1'b0; bus2.ch_mode = 1'b1; bus2.ch_limit = LIM;
    tbl[0]  = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 3, 0, 0, 0, 2'b00);
    tbl[1]  = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 1, 1, 0, 0, 2'b00);
    tbl[2]  = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 3, 0, 1, 0, 2'b00);
    tbl[3]  = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 1, 1, 1, 0, 2'b00);
    tbl[4]  = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 3, 0, 2, 0, 2'b00);
    tbl[5]  = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 1, 1, 2, 0, 2'b00);
    tbl[6]  = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 1, 0, 3, 0, 2'b01);
    tbl[7]  = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 2, 0, 3, 0, 2'b00);
    tbl[8]  = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 1, 1, 3, 0, 2'b00);
    tbl[9]  = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 1, 0, 0, 0, 2'b00);
    tbl[10] = mk(0, 2'b01, 2'b00, 2'b00, 3, 0, 5, 0, 0, 0, 2'b00);
    tbl[11] = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 2, 0, 0, 0, 2'b00);
    tbl[12] = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 1, 1, 0, 0, 2'b00);
    tbl[13] = mk(1, 2'b01, 2'b00, 2'b00, 3, 0, 1, 0, 1, 0, 2'b00);
    for (int k = 0; k < 3; k++) step();
    chk("rst_tick", {31'd0, bus.tick}, 0);
    chk("rst_c0", bus.ch_count[7:0], 0);
    chk("rst_c1", bus.ch_count[15:8], 0);
    chk("rst_done", bus.ch_done, 0);
    chk("rst_w29", bus2.ch_count, 0);
    resetn = 1'b1;
    for (int r = 0; r < 14; r++) begin
      bus.tick_en = tbl[r].en; bus.ch_run = tbl[r].run; bus.ch_clear = tbl[r].clr; bus.ch_mode = tbl[r].mode;
      bus.ch_limit = {tbl[r].l1, tbl[r].l0};
      for (int k = 0; k < tbl[r].n; k++) begin
        step();
        chk($sformatf("vec%0d_tick", r), {31'd0, bus.tick}, {31'd0, tbl[r].tk});
        chk($sformatf("vec%0d_c0", r), bus.ch_count[7:0], tbl[r].c0);
        chk($sformatf("vec%0d_c1", r), bus.ch_count[15:8], tbl[r].c1);
        chk($sformatf("vec%0d_done", r), bus.ch_done, tbl[r].dn);
      end
    end
    bus.ch_clear = 2'b11;
    step();
    chk("clr_c0", bus.ch_count[7:0], 0);
    bus.ch_clear = 2'b00; bus.ch_run = 2'b10; bus.ch_mode = 2'b10; bus.ch_limit = {8'd5, 8'd3};
    d1_pulses = 0;
    for (int k = 1; k <= 7; k++) begin
      adv();
      chk($sformatf("stop_c1_%0d", k), bus.ch_count[15:8], (k < 5) ? k : 5);
      chk($sformatf("stop_d1_%0d", k), {31'd0, bus.ch_done[1]}, (k == 5) ? 1 : 0);
    end
    chk("stop_pulses", d1_pulses, 1);
    bus.ch_limit = {8'd7, 8'd3};
    adv();
    chk("raise_c1a", bus.ch_count[15:8], 6);
    adv();
    chk("raise_c1b", bus.ch_count[15:8], 7);
    chk("raise_d1b", {31'd0, bus.ch_done[1]}, 1);
    adv();
    chk("raise_c1c", bus.ch_count[15:8], 7);
    chk("raise_pulses", d1_pulses, 2);
    chk("idle_c0", bus.ch_count[7:0], 0);
    bus.ch_run = 2'b01; bus.ch_mode = 2'b00; bus.ch_limit = {8'd7, 8'd6};
    adv();
    adv();
    chk("pre_clr_c0", bus.ch_count[7:0], 2);
    next_tick();
    bus.ch_clear = 2'b01;
    step();
    chk("clr_tick_c0", bus.ch_count[7:0], 0);
    chk("clr_tick_d0", {31'd0, bus.ch_done[0]}, 0);
    bus.ch_clear = 2'b00;
    adv();
    chk("post_clr_c0", bus.ch_count[7:0], 1);
    for (int k = 0; k < 3; k++) adv();
    chk("pre_drop_c0", bus.ch_count[7:0], 4);
    bus.ch_limit = {8'd7, 8'd2};
    adv();
    chk("drop_c0", bus.ch_count[7:0], 0);
    chk("drop_d0", {31'd0, bus.ch_done[0]}, 0);
    adv();
    chk("pre_zero_c0", bus.ch_count[7:0], 1);
    bus.ch_limit = {8'd7, 8'd0}; bus.ch_mode = 2'b01;
    seen = 2'b00;
    for (int k = 0; k < 3; k++) begin
      adv();
      chk($sformatf("zero_c0_%0d", k), bus.ch_count[7:0], 0);
    end
    chk("zero_no_done", {31'd0, seen[0]}, 0);
    bus.ch_clear = 2'b11;
    step();
    bus.ch_clear = 2'b00; bus.ch_mode = 2'b00; bus.ch_run = 2'b11; bus.ch_limit = {8'd200, 8'd200};
    adv();
    adv();
    chk("both_c0", bus.ch_count[7:0], 2);
    chk("both_c1", bus.ch_count[15:8], 2);
    bus.ch_run = 2'b10;
    for (int k = 0; k < 10; k++) adv();
    chk("pause_c0", bus.ch_count[7:0], 2);
    chk("pause_c1", bus.ch_count[15:8], 12);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_tick", {31'd0, bus.tick}, 0);
    chk("async_c0", bus.ch_count[7:0], 0);
    chk("async_c1", bus.ch_count[15:8], 0);
    chk("async_done", bus.ch_done, 0);
    step();
    resetn = 1'b1;
    step();
    step();
    force dut2.g_ch[0].u_ch.count = 29'd536870908;
    step();
    release dut2.g_ch[0].u_ch.count;
    bus2.ch_run = 1'b1;
    step();
    chk("w29_a", bus2.ch_count, 29'd536870909);
    step();
    chk("w29_b", bus2.ch_count, 29'd536870910);
    step();
    chk("w29_c", bus2.ch_count, LIM);
    chk("w29_done", {31'd0, bus2.ch_done}, 1);
    step();
    chk("w29_hold", bus2.ch_count, LIM);
    chk("w29_done_off", {31'd0, bus2.ch_done}, 0);
    step();
    chk("w29_hold2", bus2.ch_count, LIM);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
